// File: rtl/reg_intf_pkg.sv
// Shared types and constants for the host register bus and its regfile blocks.
package reg_intf_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } regbus_state_e;

    localparam logic [5:0] BLK_TOP  = 6'h00;
    localparam logic [5:0] BLK_CONV = 6'h01;

    localparam int unsigned REG_ADDR_W = 14;
    localparam int unsigned REG_DATA_W = 16;
    localparam int unsigned ERR_CNT_W  = 8;

endpackage

// File: rtl/reg_bus_bridge.sv
// Host-side register-bus master: one request at a time, single-cycle regfile strobe,
// block read-data select and a valid/ready response with unmapped-address error flag.
module reg_bus_bridge
    import reg_intf_pkg::*;
#(
    parameter int unsigned            NUM_BLOCKS = 4,
    parameter logic [NUM_BLOCKS-1:0]  BLK_MAP    = NUM_BLOCKS'((1 << BLK_TOP) | (1 << BLK_CONV)),
    parameter int unsigned            ADDR_W     = REG_ADDR_W,
    parameter int unsigned            DATA_W     = REG_DATA_W
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic                         req_write,
    input  logic [ADDR_W-1:0]            req_addr,
    input  logic [DATA_W-1:0]            req_wdata,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [DATA_W-1:0]            rsp_rdata,
    output logic                         rsp_err,
    output logic                         wr_en,
    output logic                         rd_en,
    output logic [ADDR_W-1:0]            addr,
    output logic [DATA_W-1:0]            write_data,
    input  logic [NUM_BLOCKS*DATA_W-1:0] read_data_blk,
    output logic [ERR_CNT_W-1:0]         err_count
);

    localparam int unsigned BLK_LSB   = 8;
    localparam int unsigned BLK_W     = 6;
    localparam int unsigned BLK_IDX_W = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;

    regbus_state_e          state;
    logic                   write_q;
    logic                   hit_q;
    logic [BLK_IDX_W-1:0]   blk_idx_q;

    logic [BLK_W-1:0]       req_blk_c;
    logic                   req_hit_c;
    logic [DATA_W-1:0]      blk_rdata_c;

    assign req_ready = (state == IDLE);
    assign req_blk_c = req_addr[BLK_LSB +: BLK_W];

    // Block decode: only indices below NUM_BLOCKS with their map bit set are hits.
    always_comb begin
        req_hit_c = 1'b0;
        for (int unsigned i = 0; i < NUM_BLOCKS; i++) begin
            if (req_blk_c == BLK_W'(i) && BLK_MAP[i]) begin
                req_hit_c = 1'b1;
            end
        end
    end

    // Regfile reads are combinational; only sampled at the end of ACCESS on a hit.
    assign blk_rdata_c = read_data_blk[blk_idx_q*DATA_W +: DATA_W];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            write_q    <= 1'b0;
            hit_q      <= 1'b0;
            blk_idx_q  <= '0;
            wr_en      <= 1'b0;
            rd_en      <= 1'b0;
            addr       <= '0;
            write_data <= '0;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= '0;
            rsp_err    <= 1'b0;
            err_count  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        addr       <= req_addr;
                        write_data <= req_wdata;
                        write_q    <= req_write;
                        hit_q      <= req_hit_c;
                        blk_idx_q  <= BLK_IDX_W'(req_blk_c);
                        wr_en      <= req_hit_c && req_write;
                        rd_en      <= req_hit_c && !req_write;
                        state      <= ACCESS;
                    end
                end
                ACCESS: begin
                    wr_en     <= 1'b0;
                    rd_en     <= 1'b0;
                    rsp_rdata <= (hit_q && !write_q) ? blk_rdata_c : '0;
                    rsp_err   <= !hit_q;
                    if (!hit_q && err_count != '1) begin
                        err_count <= err_count + ERR_CNT_W'(1);
                    end
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_reg_bus_bridge.sv
// Self-checking bench for reg_bus_bridge: directed scenarios plus randomized traffic
// checked against an address-map reference model.
module tb_reg_bus_bridge;

    localparam int NB = 4;
    localparam int AW = 14;
    localparam int DW = 16;
    localparam logic [NB-1:0] MAP = 4'b0011;

    logic           clk;
    logic           rst;
    logic           req_valid;
    logic           req_ready;
    logic           req_write;
    logic [AW-1:0]  req_addr;
    logic [DW-1:0]  req_wdata;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [DW-1:0]  rsp_rdata;
    logic           rsp_err;
    logic           wr_en;
    logic           rd_en;
    logic [AW-1:0]  addr;
    logic [DW-1:0]  write_data;
    logic [NB*DW-1:0] read_data_blk;
    logic [7:0]     err_count;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_errs = 0;

    reg_bus_bridge dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .wr_en        (wr_en),
        .rd_en        (rd_en),
        .addr         (addr),
        .write_data   (write_data),
        .read_data_blk(read_data_blk),
        .err_count    (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Reference model: the address map and the returned data
    function automatic logic model_hit(input logic [AW-1:0] a);
        int b;
        b = int'(a[13:8]);
        if (b >= NB) return 1'b0;
        return MAP[b];
    endfunction

    function automatic logic [DW-1:0] model_rdata(input logic w, input logic [AW-1:0] a);
        if (w || !model_hit(a)) return '0;
        return read_data_blk[int'(a[13:8])*DW +: DW];
    endfunction

    function automatic int model_err_next(input int cur, input logic hit);
        if (hit) return cur;
        return (cur < 255) ? cur + 1 : 255;
    endfunction

    // Drives one request with rsp_ready=1 and reports what was observed on the bus
    task automatic run_txn(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                           output int lat, output int wr_cnt, output int rd_cnt,
                           output logic [AW-1:0] s_addr, output logic [DW-1:0] s_wdata,
                           output logic [DW-1:0] rdata, output logic err, output logic overlap);
        int guard;
        lat = -1; wr_cnt = 0; rd_cnt = 0; s_addr = '0; s_wdata = '0;
        rdata = '0; err = 1'b0; overlap = 1'b0;
        @(negedge clk);
        guard = 0;
        while (!req_ready && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; rsp_ready = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            if (wr_en) begin wr_cnt++; s_addr = addr; s_wdata = write_data; end
            if (rd_en) begin rd_cnt++; s_addr = addr; end
            if (wr_en && rd_en) overlap = 1'b1;
            if (rsp_valid) begin
                lat = c; rdata = rsp_rdata; err = rsp_err;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        rsp_ready = 1'b0; read_data_blk = '0;
        #23;
        n_tests++;
        if ({wr_en, rd_en, rsp_valid, rsp_err} !== 4'b0) begin
            n_fail++; $display("FAIL reset_flags got %b exp 0000", {wr_en, rd_en, rsp_valid, rsp_err});
        end
        n_tests++;
        if (addr !== '0 || write_data !== '0 || rsp_rdata !== '0 || err_count !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_regs got addr=%h wd=%h rd=%h ec=%0d exp all 0",
                     addr, write_data, rsp_rdata, err_count);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_tests++;
        if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready got %b exp 1", req_ready); end
        exp_errs = 0;
    endtask

    task automatic test_write();
        int lat, wc, rc; logic [AW-1:0] sa; logic [DW-1:0] sd, rdv; logic er, ov;
        run_txn(1'b1, 14'h101, 16'hABCD, lat, wc, rc, sa, sd, rdv, er, ov);
        n_tests++;
        if (wc !== 1 || rc !== 0) begin n_fail++; $display("FAIL write_strobes got wr=%0d rd=%0d exp 1 0", wc, rc); end
        n_tests++;
        if (sa !== 14'h101 || sd !== 16'hABCD) begin
            n_fail++; $display("FAIL write_bus got addr=%h data=%h exp 0101 abcd", sa, sd);
        end
        n_tests++;
        if (lat !== 2) begin n_fail++; $display("FAIL write_latency got %0d exp 2", lat); end
        n_tests++;
        if (er !== 1'b0 || rdv !== 16'h0) begin n_fail++; $display("FAIL write_rsp got err=%b rdata=%h exp 0 0000", er, rdv); end
        @(negedge clk);
        n_tests++;
        if (addr !== 14'h101 || write_data !== 16'hABCD) begin
            n_fail++; $display("FAIL write_hold got addr=%h data=%h exp 0101 abcd", addr, write_data);
        end
    endtask

    task automatic test_read();
        int lat, wc, rc; logic [AW-1:0] sa; logic [DW-1:0] sd, rdv; logic er, ov;
        read_data_blk = {16'($urandom), 16'($urandom), 16'hABCD, 16'($urandom)};
        run_txn(1'b0, 14'h101, 16'($urandom), lat, wc, rc, sa, sd, rdv, er, ov);
        n_tests++;
        if (rc !== 1 || wc !== 0) begin n_fail++; $display("FAIL read_strobes got wr=%0d rd=%0d exp 0 1", wc, rc); end
        n_tests++;
        if (rdv !== 16'hABCD || er !== 1'b0) begin n_fail++; $display("FAIL read_rsp got rdata=%h err=%b exp abcd 0", rdv, er); end
        n_tests++;
        if (lat !== 2) begin n_fail++; $display("FAIL read_latency got %0d exp 2", lat); end
    endtask

    task automatic test_unmapped();
        logic [AW-1:0] addrs [3];
        logic          wrs   [3];
        int lat, wc, rc; logic [AW-1:0] sa; logic [DW-1:0] sd, rdv; logic er, ov;
        addrs[0] = 14'h305; wrs[0] = 1'b0;
        addrs[1] = 14'h2A0; wrs[1] = 1'b1;
        addrs[2] = 14'h3FFF; wrs[2] = 1'b0;
        read_data_blk = {$urandom, $urandom};
        for (int i = 0; i < 3; i++) begin
            run_txn(wrs[i], addrs[i], 16'($urandom), lat, wc, rc, sa, sd, rdv, er, ov);
            exp_errs = model_err_next(exp_errs, 1'b0);
            n_tests++;
            if (wc + rc !== 0) begin n_fail++; $display("FAIL unmapped_strobe[%0d] got %0d exp 0", i, wc + rc); end
            n_tests++;
            if (er !== 1'b1 || rdv !== 16'h0) begin
                n_fail++; $display("FAIL unmapped_rsp[%0d] got err=%b rdata=%h exp 1 0000", i, er, rdv);
            end
            n_tests++;
            if (int'(err_count) !== exp_errs) begin
                n_fail++; $display("FAIL unmapped_count[%0d] got %0d exp %0d", i, err_count, exp_errs);
            end
        end
    endtask

    task automatic test_hold();
        logic [DW-1:0] exp_rd;
        read_data_blk = {$urandom, $urandom};
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 14'h1AA; rsp_ready = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        exp_rd = model_rdata(1'b0, 14'h1AA);
        @(negedge clk);
        n_tests++;
        if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL hold_rsp_valid got %b exp 1", rsp_valid); end
        for (int k = 0; k < 5; k++) begin
            read_data_blk = {$urandom, $urandom};
            req_valid = 1'b1; req_write = 1'b1; req_addr = 14'h101;
            @(negedge clk);
            n_tests++;
            if (rsp_valid !== 1'b1 || rsp_rdata !== exp_rd || rsp_err !== 1'b0) begin
                n_fail++;
                $display("FAIL hold_stable[%0d] got v=%b rdata=%h err=%b exp 1 %h 0", k, rsp_valid, rsp_rdata, rsp_err, exp_rd);
            end
            n_tests++;
            if (req_ready !== 1'b0 || wr_en !== 1'b0 || rd_en !== 1'b0) begin
                n_fail++; $display("FAIL hold_blocked[%0d] got ready=%b wr=%b rd=%b exp 0 0 0", k, req_ready, wr_en, rd_en);
            end
        end
        req_valid = 1'b0; rsp_ready = 1'b1;
        @(negedge clk);
        n_tests++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            n_fail++; $display("FAIL hold_release got v=%b ready=%b exp 0 1", rsp_valid, req_ready);
        end
    endtask

    task automatic test_back_to_back();
        logic [DW:0] exp_q[$];
        logic [DW:0] got, expv;
        int acc_cyc[$];
        logic pending;
        logic ov;
        pending = 1'b0; ov = 1'b0;
        read_data_blk = {$urandom, $urandom};
        rsp_ready = 1'b1;
        for (int cyc = 0; cyc < 36; cyc++) begin
            @(negedge clk);
            if (rsp_valid) begin
                got = {rsp_err, rsp_rdata};
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++; $display("FAIL b2b_unexpected_rsp got %h exp none", got);
                end else begin
                    expv = exp_q.pop_front();
                    if (got !== expv) begin n_fail++; $display("FAIL b2b_rsp got %h exp %h", got, expv); end
                end
            end
            if (wr_en && rd_en) ov = 1'b1;
            if (cyc == 0 || pending) begin
                req_valid = 1'b1;
                req_write = 1'($urandom);
                req_addr  = {6'($urandom_range(0, 4)), 8'($urandom)};
                req_wdata = 16'($urandom);
                pending   = 1'b0;
            end
            if (cyc == 35) req_valid = 1'b0;
            if (req_ready && req_valid) begin
                acc_cyc.push_back(cyc);
                exp_q.push_back({!model_hit(req_addr), model_rdata(req_write, req_addr)});
                exp_errs = model_err_next(exp_errs, model_hit(req_addr));
                pending = 1'b1;
            end
        end
        for (int d = 0; d < 8 && exp_q.size() > 0; d++) begin
            @(negedge clk);
            if (rsp_valid) begin
                got = {rsp_err, rsp_rdata};
                expv = exp_q.pop_front();
                n_tests++;
                if (got !== expv) begin n_fail++; $display("FAIL b2b_drain_rsp got %h exp %h", got, expv); end
            end
        end
        n_tests++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL b2b_missing_rsp got %0d left exp 0", exp_q.size()); end
        n_tests++;
        if (acc_cyc.size() < 10) begin n_fail++; $display("FAIL b2b_accepts got %0d exp >=10", acc_cyc.size()); end
        for (int i = 1; i < acc_cyc.size(); i++) begin
            n_tests++;
            if (acc_cyc[i] - acc_cyc[i-1] !== 3) begin
                n_fail++; $display("FAIL b2b_gap[%0d] got %0d exp 3", i, acc_cyc[i] - acc_cyc[i-1]);
            end
        end
        n_tests++;
        if (ov !== 1'b0) begin n_fail++; $display("FAIL b2b_overlap got %b exp 0", ov); end
        n_tests++;
        if (int'(err_count) !== exp_errs) begin n_fail++; $display("FAIL b2b_count got %0d exp %0d", err_count, exp_errs); end
    endtask

    task automatic test_random();
        int lat, wc, rc; logic [AW-1:0] sa; logic [DW-1:0] sd, rdv; logic er, ov;
        logic w, hit; logic [AW-1:0] a; logic [DW-1:0] d, exp_rd;
        for (int t = 0; t < 40; t++) begin
            read_data_blk = {$urandom, $urandom};
            w = 1'($urandom);
            a = {(t % 7 == 6) ? 6'($urandom) : 6'($urandom_range(0, 5)), 8'($urandom)};
            d = 16'($urandom);
            hit = model_hit(a);
            exp_rd = model_rdata(w, a);
            run_txn(w, a, d, lat, wc, rc, sa, sd, rdv, er, ov);
            exp_errs = model_err_next(exp_errs, hit);
            n_tests++;
            if (lat !== 2 || ov !== 1'b0) begin n_fail++; $display("FAIL rand_timing[%0d] got lat=%0d ov=%b exp 2 0", t, lat, ov); end
            n_tests++;
            if (wc !== int'(hit && w) || rc !== int'(hit && !w)) begin
                n_fail++; $display("FAIL rand_strobe[%0d] a=%h w=%b got wr=%0d rd=%0d hit=%b", t, a, w, wc, rc, hit);
            end
            n_tests++;
            if (hit && (sa !== a || (w && sd !== d))) begin
                n_fail++; $display("FAIL rand_bus[%0d] got addr=%h data=%h exp %h %h", t, sa, sd, a, d);
            end
            n_tests++;
            if (rdv !== exp_rd || er !== !hit) begin
                n_fail++; $display("FAIL rand_rsp[%0d] a=%h got rdata=%h err=%b exp %h %b", t, a, rdv, er, exp_rd, !hit);
            end
            n_tests++;
            if (int'(err_count) !== exp_errs) begin n_fail++; $display("FAIL rand_count[%0d] got %0d exp %0d", t, err_count, exp_errs); end
        end
    endtask

    task automatic test_reset_mid_access();
        @(negedge clk);
        n_tests++;
        if (err_count === 8'd0) begin n_fail++; $display("FAIL rstmid_precount got 0 exp nonzero"); end
        req_valid = 1'b1; req_write = 1'b1; req_addr = 14'h1F0; req_wdata = 16'h5A5A; rsp_ready = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        n_tests++;
        if (wr_en !== 1'b1) begin n_fail++; $display("FAIL rstmid_strobe got %b exp 1", wr_en); end
        #1 rst = 1'b0;
        #1;
        n_tests++;
        if (wr_en !== 1'b0 || rsp_valid !== 1'b0 || err_count !== 8'd0) begin
            n_fail++; $display("FAIL rstmid_async got wr=%b v=%b ec=%0d exp 0 0 0", wr_en, rsp_valid, err_count);
        end
        exp_errs = 0;
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_tests++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || wr_en !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_after got v=%b ready=%b wr=%b exp 0 1 0", rsp_valid, req_ready, wr_en);
        end
    endtask

    task automatic test_saturate();
        int lat, wc, rc; logic [AW-1:0] sa; logic [DW-1:0] sd, rdv; logic er, ov;
        logic [AW-1:0] a;
        for (int i = 0; i < 260; i++) begin
            a = {6'($urandom_range(2, 63)), 8'($urandom)};
            run_txn(1'($urandom), a, 16'($urandom), lat, wc, rc, sa, sd, rdv, er, ov);
            exp_errs = model_err_next(exp_errs, 1'b0);
            n_tests++;
            if (int'(err_count) !== exp_errs || er !== 1'b1) begin
                n_fail++; $display("FAIL sat_count[%0d] got ec=%0d err=%b exp %0d 1", i, err_count, er, exp_errs);
            end
        end
        n_tests++;
        if (err_count !== 8'hFF) begin n_fail++; $display("FAIL sat_final got %h exp ff", err_count); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_unmapped();
        test_hold();
        test_back_to_back();
        test_random();
        test_reset_mid_access();
        test_saturate();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
